// File: rtl/multi_prescaled_scaler_bank_if.sv
// Readout stream of the scaler bank: one channel snapshot per valid/ready beat.
// The producer drives the master modport; the consumer uses the slave modport.
interface multi_prescaled_scaler_bank_if #(
  parameter int WIDTH  = 24,
  parameter int CHAN_W = 2
);
  logic [WIDTH-1:0]  value_o;
  logic [CHAN_W-1:0] chan_o;
  logic              overflow_o;
  logic              last_o;
  logic              value_valid_o;
  logic              value_ready_i;

  modport master (
    output value_o, chan_o, overflow_o, last_o, value_valid_o,
    input  value_ready_i
  );

  modport slave (
    input  value_o, chan_o, overflow_o, last_o, value_valid_o,
    output value_ready_i
  );
endinterface

// File: rtl/multi_prescaled_scaler_bank.sv
// Bank of NCHAN prescaled, saturating rate scalers. An update request snapshots and
// restarts every channel at once, then the snapshot is streamed out one channel per beat.
module multi_prescaled_scaler_bank #(
  parameter int    NCHAN          = 4,
  parameter int    WIDTH          = 24,
  parameter int    PRESCALE_BITS  = 8,
  parameter string PIPELINE_INPUT = "TRUE"
) (
  input  logic                           fast_clk_i,
  input  logic                           fast_rst_n_i,
  input  logic [NCHAN*PRESCALE_BITS-1:0] prescale_i,
  input  logic [NCHAN-1:0]               count_i,
  input  logic                           update_i,
  output logic                           update_dropped_o,
  multi_prescaled_scaler_bank_if.master  rd
);

  localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NCHAN - 1);

  typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
    if (!fast_rst_n_i) rst_sync_q <= '0;
    else               rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Count pulses and update share one delay so the interval boundary is identical.
  logic [NCHAN-1:0] cnt_d;
  logic             upd_d;

  generate
    if (PIPELINE_INPUT == "TRUE") begin : g_pipe
      always_ff @(posedge fast_clk_i or negedge rst_n) begin
        if (!rst_n) begin
          cnt_d <= '0;
          upd_d <= 1'b0;
        end else begin
          cnt_d <= count_i;
          upd_d <= update_i;
        end
      end
    end else begin : g_nopipe
      always_comb begin
        cnt_d = count_i;
        upd_d = update_i;
      end
    end
  endgenerate

  state_t                   state_q;
  logic                     presc_init_q;
  logic [PRESCALE_BITS-1:0] presc_q  [NCHAN];
  logic [PRESCALE_BITS-1:0] resid_q  [NCHAN];
  logic [WIDTH-1:0]         live_q   [NCHAN];
  logic [WIDTH-1:0]         snap_q   [NCHAN];
  logic [NCHAN-1:0]         live_ovf_q;
  logic [NCHAN-1:0]         snap_ovf_q;
  logic [NCHAN-1:0]         inc;
  logic                     accept;

  assign accept = upd_d && (state_q == IDLE);

  // ">=" keeps a residue left above a newly lowered prescale from running away.
  always_comb begin
    inc = '0;
    for (int unsigned k = 0; k < NCHAN; k++)
      inc[k] = cnt_d[k] && (resid_q[k] >= presc_q[k]);
  end

  always_ff @(posedge fast_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      presc_init_q <= 1'b1;
      live_ovf_q   <= '0;
      snap_ovf_q   <= '0;
      for (int unsigned k = 0; k < NCHAN; k++) begin
        presc_q[k] <= '0;
        resid_q[k] <= '0;
        live_q[k]  <= '0;
        snap_q[k]  <= '0;
      end
    end else begin
      presc_init_q <= 1'b0;
      for (int unsigned k = 0; k < NCHAN; k++) begin
        if (presc_init_q || accept)
          presc_q[k] <= prescale_i[k*PRESCALE_BITS +: PRESCALE_BITS];
        if (cnt_d[k])
          resid_q[k] <= inc[k] ? '0 : resid_q[k] + 1'b1;
        if (accept) begin
          // The pulse seen on the snapshot edge opens the new interval.
          snap_q[k]     <= live_q[k];
          snap_ovf_q[k] <= live_ovf_q[k];
          live_q[k]     <= inc[k] ? WIDTH'(1) : '0;
          live_ovf_q[k] <= 1'b0;
        end else if (inc[k]) begin
          if (live_q[k] == '1) live_ovf_q[k] <= 1'b1;
          else                 live_q[k]     <= live_q[k] + 1'b1;
        end
      end
    end
  end

  logic [CHAN_W-1:0] chan_q;
  logic [CHAN_W-1:0] nxt_chan;
  logic [WIDTH-1:0]  value_q;
  logic              ovf_q;
  logic              last_q;
  logic              valid_q;
  logic              dropped_q;

  assign nxt_chan = chan_q + 1'b1;

  always_ff @(posedge fast_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      chan_q    <= '0;
      value_q   <= '0;
      ovf_q     <= 1'b0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= upd_d && (state_q != IDLE);
      case (state_q)
        IDLE: if (upd_d) state_q <= SNAP;
        SNAP: begin
          state_q <= SEND;
          valid_q <= 1'b1;
          chan_q  <= '0;
          value_q <= snap_ovf_q[0] ? '1 : snap_q[0];
          ovf_q   <= snap_ovf_q[0];
          last_q  <= (NCHAN == 1);
        end
        SEND: if (rd.value_ready_i) begin
          if (chan_q == LAST_CHAN) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            chan_q  <= '0;
            value_q <= '0;
            ovf_q   <= 1'b0;
          end else begin
            chan_q  <= nxt_chan;
            value_q <= snap_ovf_q[nxt_chan] ? '1 : snap_q[nxt_chan];
            ovf_q   <= snap_ovf_q[nxt_chan];
            last_q  <= (nxt_chan == LAST_CHAN);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd.value_o         = value_q;
  assign rd.chan_o          = chan_q;
  assign rd.overflow_o      = ovf_q;
  assign rd.last_o          = last_q;
  assign rd.value_valid_o   = valid_q;
  assign update_dropped_o   = dropped_q;

endmodule

// File: tb/tb_multi_prescaled_scaler_bank.sv
// Directed bench for the scaler bank: main instance (WIDTH=8, pipelined input) plus an
// unpipelined twin used only to confirm the shorter update-to-valid latency.
module tb_multi_prescaled_scaler_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] prescale_i = '0;
  logic [3:0]  count_i = '0;
  logic        update_i = 1'b0;
  logic        dropped, dropped2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] bv;
  logic [1:0] bc;
  logic       bo, bl;

  multi_prescaled_scaler_bank_if #(.WIDTH(8), .CHAN_W(2)) rd ();
  multi_prescaled_scaler_bank_if #(.WIDTH(8), .CHAN_W(2)) rd2 ();

  multi_prescaled_scaler_bank #(
    .NCHAN(4), .WIDTH(8), .PRESCALE_BITS(8), .PIPELINE_INPUT("TRUE")
  ) dut (
    .fast_clk_i(clk), .fast_rst_n_i(rst_n), .prescale_i(prescale_i),
    .count_i(count_i), .update_i(update_i), .update_dropped_o(dropped), .rd(rd)
  );

  multi_prescaled_scaler_bank #(
    .NCHAN(4), .WIDTH(8), .PRESCALE_BITS(8), .PIPELINE_INPUT("FALSE")
  ) dut2 (
    .fast_clk_i(clk), .fast_rst_n_i(rst_n), .prescale_i(prescale_i),
    .count_i(count_i), .update_i(update_i), .update_dropped_o(dropped2), .rd(rd2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update();
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
  endtask

  task automatic pulses(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      count_i = mask;
      tick();
    end
    count_i = '0;
  endtask

  // Waits (bounded) for a valid beat, captures it, and lets the next edge accept it.
  task automatic get_beat(output logic [7:0] v, output logic [1:0] c,
                          output logic o, output logic l);
    int n = 0;
    while (rd.value_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (rd.value_valid_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: valid=%b after %0d cycles, required 1", rd.value_valid_o, n);
    end
    v = rd.value_o;
    c = rd.chan_o;
    o = rd.overflow_o;
    l = rd.last_o;
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks++; if (rd.value_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rd.value_valid_o); end
    checks++; if (rd.value_o !== 8'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", rd.value_o); end
    checks++; if (rd.chan_o !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", rd.chan_o); end
    checks++; if (rd.last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", rd.last_o); end
    checks++; if (rd.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", rd.overflow_o); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_basic_and_latency();
    logic [7:0] exp_v [4] = '{8'd10, 8'd3, 8'd0, 8'd0};
    for (int i = 0; i < 10; i++) begin
      count_i = {2'b00, (i < 3), 1'b1};
      tick();
    end
    count_i = '0;
    tick();
    do_update();
    checks++; if (rd2.value_valid_o !== 1'b0) begin errors++; $display("FAIL lat_nopipe_early: got %b want 0", rd2.value_valid_o); end
    tick();
    checks++; if (rd2.value_valid_o !== 1'b1) begin errors++; $display("FAIL lat_nopipe_2: got %b want 1", rd2.value_valid_o); end
    checks++; if (rd.value_valid_o !== 1'b0) begin errors++; $display("FAIL lat_pipe_early: got %b want 0", rd.value_valid_o); end
    tick();
    checks++; if (rd.value_valid_o !== 1'b1) begin errors++; $display("FAIL lat_pipe_3: got %b want 1", rd.value_valid_o); end
    for (int i = 0; i < 4; i++) begin
      get_beat(bv, bc, bo, bl);
      checks++; if (bc !== 2'(i)) begin errors++; $display("FAIL basic_chan%0d: got %0d want %0d", i, bc, i); end
      checks++; if (bv !== exp_v[i]) begin errors++; $display("FAIL basic_value%0d: got %0d want %0d", i, bv, exp_v[i]); end
      checks++; if (bl !== (i == 3)) begin errors++; $display("FAIL basic_last%0d: got %b want %b", i, bl, (i == 3)); end
    end
    checks++; if (rd.value_valid_o !== 1'b0) begin errors++; $display("FAIL basic_idle: valid=%b want 0", rd.value_valid_o); end
  endtask

  task automatic test_prescale_residue();
    prescale_i = 32'h0003_0000;
    do_update();
    for (int i = 0; i < 4; i++) get_beat(bv, bc, bo, bl);
    pulses(4'b0100, 17);
    tick();
    do_update();
    for (int i = 0; i < 4; i++) begin
      get_beat(bv, bc, bo, bl);
      if (i == 2) begin
        checks++; if (bv !== 8'd4) begin errors++; $display("FAIL presc_first: got %0d want 4", bv); end
      end
    end
    pulses(4'b0100, 5);
    tick();
    do_update();
    for (int i = 0; i < 4; i++) begin
      get_beat(bv, bc, bo, bl);
      if (i == 2) begin
        checks++; if (bv !== 8'd1) begin errors++; $display("FAIL presc_residue: got %0d want 1", bv); end
      end
    end
  endtask

  task automatic test_overflow();
    pulses(4'b0010, 300);
    tick();
    do_update();
    for (int i = 0; i < 4; i++) begin
      get_beat(bv, bc, bo, bl);
      if (i == 1) begin
        checks++; if (bv !== 8'd255) begin errors++; $display("FAIL ovf_value: got %0d want 255", bv); end
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bo); end
      end
    end
    do_update();
    for (int i = 0; i < 4; i++) begin
      get_beat(bv, bc, bo, bl);
      if (i == 1) begin
        checks++; if (bv !== 8'd0) begin errors++; $display("FAIL ovf_next_value: got %0d want 0", bv); end
        checks++; if (bo !== 1'b0) begin errors++; $display("FAIL ovf_next_flag: got %b want 0", bo); end
      end
    end
  endtask

  task automatic test_boundary_pulse();
    pulses(4'b0001, 2);
    tick();
    count_i = 4'b0001;
    update_i = 1'b1;
    tick();
    count_i = '0;
    update_i = 1'b0;
    get_beat(bv, bc, bo, bl);
    checks++; if (bv !== 8'd2) begin errors++; $display("FAIL boundary_excl: got %0d want 2", bv); end
    for (int i = 1; i < 4; i++) get_beat(bv, bc, bo, bl);
    do_update();
    get_beat(bv, bc, bo, bl);
    checks++; if (bv !== 8'd1) begin errors++; $display("FAIL boundary_incl: got %0d want 1", bv); end
    for (int i = 1; i < 4; i++) get_beat(bv, bc, bo, bl);
  endtask

  task automatic test_stall_and_drop();
    for (int i = 0; i < 6; i++) begin
      count_i = {1'b1, 1'b0, (i < 4), (i < 1)};
      tick();
    end
    count_i = '0;
    tick();
    do_update();
    get_beat(bv, bc, bo, bl);
    checks++; if (bv !== 8'd1 || bc !== 2'd0) begin errors++; $display("FAIL stall_beat0: got ch%0d=%0d want ch0=1", bc, bv); end
    rd.value_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (rd.value_valid_o !== 1'b1 || rd.chan_o !== 2'd1 || rd.value_o !== 8'd4) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b ch%0d=%0d want v=1 ch1=4", s, rd.value_valid_o, rd.chan_o, rd.value_o);
      end
      if (s == 1) update_i = 1'b1;
      tick();
      update_i = 1'b0;
      checks++;
      if (dropped !== (s == 2)) begin
        errors++;
        $display("FAIL stall_dropped%0d: got %b want %b", s, dropped, (s == 2));
      end
    end
    rd.value_ready_i = 1'b1;
    get_beat(bv, bc, bo, bl);
    checks++; if (bv !== 8'd4 || bc !== 2'd1) begin errors++; $display("FAIL stall_beat1: got ch%0d=%0d want ch1=4", bc, bv); end
    get_beat(bv, bc, bo, bl);
    checks++; if (bv !== 8'd0 || bc !== 2'd2) begin errors++; $display("FAIL stall_beat2: got ch%0d=%0d want ch2=0", bc, bv); end
    get_beat(bv, bc, bo, bl);
    checks++; if (bv !== 8'd6 || bc !== 2'd3 || bl !== 1'b1) begin errors++; $display("FAIL stall_beat3: got ch%0d=%0d last=%b want ch3=6 last=1", bc, bv, bl); end
    checks++; if (rd.value_valid_o !== 1'b0) begin errors++; $display("FAIL stall_idle: valid=%b want 0", rd.value_valid_o); end
  endtask

  task automatic test_reset_midstream();
    pulses(4'b0001, 3);
    tick();
    do_update();
    get_beat(bv, bc, bo, bl);
    get_beat(bv, bc, bo, bl);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd.value_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rd.value_valid_o); end
    checks++; if (rd.chan_o !== 2'd0) begin errors++; $display("FAIL midrst_chan: got %0d want 0", rd.chan_o); end
    checks++; if (rd.value_o !== 8'd0) begin errors++; $display("FAIL midrst_value: got %0d want 0", rd.value_o); end
    checks++; if (rd.last_o !== 1'b0) begin errors++; $display("FAIL midrst_last: got %b want 0", rd.last_o); end
    prescale_i = '0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    pulses(4'b0010, 7);
    tick();
    do_update();
    for (int i = 0; i < 4; i++) begin
      get_beat(bv, bc, bo, bl);
      checks++;
      if (bc !== 2'(i) || bv !== ((i == 1) ? 8'd7 : 8'd0) || bl !== (i == 3)) begin
        errors++;
        $display("FAIL postrst_beat%0d: got ch%0d=%0d last=%b want ch%0d=%0d last=%b",
                 i, bc, bv, bl, i, ((i == 1) ? 7 : 0), (i == 3));
      end
    end
  endtask

  initial begin
    rd.value_ready_i  = 1'b1;
    rd2.value_ready_i = 1'b1;
    test_reset();
    test_basic_and_latency();
    test_prescale_residue();
    test_overflow();
    test_boundary_pulse();
    test_stall_and_drop();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
